// File: rtl/toggle_stim_pkg.sv
// Shared types and default sizing for the toggle stimulus generator.
package toggle_stim_pkg;

  localparam int NCH_D   = 3;
  localparam int CNT_W_D = 8;
  localparam int RUN_W_D = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/toggle_stim_chan.sv
// One square-wave channel. It captures its half-period and start level on
// load, then advances only while run is high. A half-period of zero
// disables toggling, so the channel holds its start level.
module toggle_stim_chan #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] half_period,
  input  logic             init_val,
  output logic             out
);

  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] cnt;

  // Load the period and level at start; count down and toggle while running.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_q <= '0;
      cnt <= '0;
      out <= 1'b0;
    end else if (load) begin
      h_q <= half_period;
      out <= init_val;
      cnt <= (half_period == '0) ? '0 : half_period - CNT_W'(1);
    end else if (run && (h_q != '0)) begin
      if (cnt == '0) begin
        out <= ~out;
        cnt <= h_q - CNT_W'(1);
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/toggle_stim_gen.sv
// N-channel periodic toggle stimulus generator with a bounded run length.
// The FSM sequences IDLE -> RUN -> DONE -> IDLE. Each channel keeps its own
// copy of the half-period, so input changes during a run have no effect.
module toggle_stim_gen
  import toggle_stim_pkg::*;
#(
  parameter int NCH   = NCH_D,
  parameter int CNT_W = CNT_W_D,
  parameter int RUN_W = RUN_W_D
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NCH*CNT_W-1:0] half_period,
  input  logic [NCH-1:0]     init_val,
  input  logic [RUN_W-1:0]   run_len,
  output logic [NCH-1:0]     stim_out,
  output logic               busy,
  output logic               done
);

  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic             free_run;
  logic             chan_load;
  logic             chan_run;

  // Start is accepted only in IDLE, and a simultaneous stop cancels it.
  assign chan_load = (state == S_IDLE) && start && !stop;
  // Channels freeze on the abort edge so stim_out keeps its last value.
  assign chan_run  = (state == S_RUN) && !stop;

  // Control FSM with a run-length counter; busy/done are registered with the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      run_cnt  <= '0;
      free_run <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (chan_load) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            free_run <= (run_len == '0);
            run_cnt  <= (run_len == '0) ? '0 : run_len - RUN_W'(1);
          end
        end
        S_RUN: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (!free_run) begin
            if (run_cnt == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              run_cnt <= run_cnt - RUN_W'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // One channel instance per output bit.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    toggle_stim_chan #(.CNT_W(CNT_W)) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (chan_load),
      .run         (chan_run),
      .half_period (half_period[i*CNT_W +: CNT_W]),
      .init_val    (init_val[i]),
      .out         (stim_out[i])
    );
  end

endmodule

// File: tb/tb_toggle_stim_gen.sv
// Directed bench for toggle_stim_gen. Outputs are sampled 1 time unit after
// each posedge; k counts edges since the start edge E0 (k=0 is E0 itself).
module tb_toggle_stim_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [23:0] half_period;
  logic [2:0]  init_val;
  logic [15:0] run_len;
  logic [2:0]  stim_out;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  toggle_stim_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .half_period (half_period),
    .init_val    (init_val),
    .run_len     (run_len),
    .stim_out    (stim_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected level k edges after E0: H==0 holds, otherwise toggles at every multiple of H.
  function automatic logic [2:0] exp_stim(input logic [2:0] init, input logic [23:0] hp, input int k);
    logic [2:0] r;
    int h;
    for (int i = 0; i < 3; i++) begin
      h = int'(hp[i*8 +: 8]);
      r[i] = (h == 0) ? init[i] : (init[i] ^ logic'((k / h) % 2));
    end
    return r;
  endfunction

  task automatic do_start(input logic [23:0] hp, input logic [2:0] iv, input logic [15:0] rl);
    half_period = hp;
    init_val    = iv;
    run_len     = rl;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  initial begin
    logic [23:0] hp;
    logic [2:0]  iv;
    logic [2:0]  held;

    // 1: reset held over three edges with start asserted
    reset_n = 1'b0; start = 1'b1; stop = 1'b0;
    half_period = {8'd7, 8'd5, 8'd1}; init_val = 3'b111; run_len = 16'd5;
    repeat (3) tick();
    chk("rst_stim", 32'(stim_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    start = 1'b0; reset_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // 2: basic run, 30 cycles
    hp = {8'd7, 8'd5, 8'd1}; iv = 3'b000;
    do_start(hp, iv, 16'd30);
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("basic_stim_k%0d", k), 32'(stim_out), 32'(exp_stim(iv, hp, k)));
      chk($sformatf("basic_busy_k%0d", k), 32'(busy), 32'd1);
      chk($sformatf("basic_done_k%0d", k), 32'(done), 32'd0);
      tick();
    end
    chk("basic_done_k30", 32'(done), 32'd1);
    chk("basic_busy_k30", 32'(busy), 32'd0);
    chk("basic_stim_k30", 32'(stim_out), 32'(exp_stim(iv, hp, 30)));
    held = exp_stim(iv, hp, 30);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("basic_post_done", 32'(done), 32'd0);
      chk("basic_post_stim", 32'(stim_out), 32'(held));
    end

    // 3 + 5: ch1 disabled with init 1; mid-run period change and start ignored
    hp = {8'd2, 8'd0, 8'd3}; iv = 3'b010;
    do_start(hp, iv, 16'd10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("dis_stim_k%0d", k), 32'(stim_out), 32'(exp_stim(iv, hp, k)));
      chk($sformatf("dis_busy_k%0d", k), 32'(busy), 32'd1);
      chk($sformatf("dis_ch1_k%0d", k), 32'(stim_out[1]), 32'd1);
      if (k == 3) half_period = {8'd1, 8'd1, 8'd1};
      if (k == 3) init_val = 3'b101;
      if (k == 3) run_len = 16'd3;
      start = (k == 5);
      tick();
    end
    start = 1'b0;
    chk("dis_done_k10", 32'(done), 32'd1);
    chk("dis_stim_k10", 32'(stim_out), 32'(exp_stim(iv, hp, 10)));
    tick();

    // 4: free run aborted by stop, then restart
    hp = {8'd4, 8'd3, 8'd2}; iv = 3'b101;
    do_start(hp, iv, 16'd0);
    for (int k = 0; k <= 12; k++) begin
      chk($sformatf("free_stim_k%0d", k), 32'(stim_out), 32'(exp_stim(iv, hp, k)));
      chk($sformatf("free_busy_k%0d", k), 32'(busy), 32'd1);
      if (k < 12) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_stim", 32'(stim_out), 32'(exp_stim(iv, hp, 12)));
    for (int j = 0; j < 2; j++) begin
      tick();
      chk("abort_idle_done", 32'(done), 32'd0);
      chk("abort_idle_stim", 32'(stim_out), 32'(exp_stim(iv, hp, 12)));
    end
    do_start(hp, iv, 16'd0);
    chk("restart_stim", 32'(stim_out), 32'(iv));
    chk("restart_busy", 32'(busy), 32'd1);
    tick();
    chk("restart_stim_k1", 32'(stim_out), 32'(exp_stim(iv, hp, 1)));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("restart_stop_busy", 32'(busy), 32'd0);

    // 5: start and stop together in IDLE
    held = stim_out;
    half_period = {8'd1, 8'd1, 8'd1}; init_val = 3'b000; run_len = 16'd4;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("race_busy", 32'(busy), 32'd0);
    chk("race_stim", 32'(stim_out), 32'(held));
    tick();
    chk("race_busy2", 32'(busy), 32'd0);
    chk("race_done2", 32'(done), 32'd0);

    // 6: reset in the middle of a run
    hp = {8'd3, 8'd2, 8'd1}; iv = 3'b110;
    do_start(hp, iv, 16'd20);
    repeat (8) tick();
    chk("mid_stim_k8", 32'(stim_out), 32'(exp_stim(iv, hp, 8)));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_stim", 32'(stim_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    for (int j = 0; j < 15; j++) begin
      tick();
      chk("midrst_no_done", 32'(done), 32'd0);
      chk("midrst_no_busy", 32'(busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
